mult_iter: RTL

MULT_ITER -- requirements
Module: mult_iter

---
 rtl/mult_iter_pkg.sv | 12 +
 rtl/mult_iter_if.sv | 27 ++
 rtl/mult_iter_add_n.sv | 14 +
 rtl/mult_iter.sv | 114 +++++++++++
 4 files changed

// File: rtl/mult_iter_pkg.sv
// Shared types and constants for the iterative multiplier.
package mult_iter_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_e;

endpackage

// File: rtl/mult_iter_if.sv
// Request/response bundle of the iterative multiplier.
interface mult_iter_if
    import mult_iter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, prod_hi, prod_lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, prod_hi, prod_lo
    );

endinterface

// File: rtl/mult_iter_add_n.sv
// N-bit ripple-style adder with carry in and carry out.
module add_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mult_iter.sv
// Shift-and-add multiplier: one multiplier bit per cycle, LSB first,
// on operand magnitudes with a final sign fix on entry to FIN.
module mult_iter
    import mult_iter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    mult_iter_if.slave   io
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 1;
    localparam int PW = 2 * WIDTH;

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] x,
        input logic             s
    );
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    state_e           state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [AW-1:0]    acc_sum;
    logic [AW-1:0]    acc_shift;
    logic [PW-1:0]    res_fin;

    assign addend = acc_q[0] ? mcand_q : '0;

    // Top accumulator bit is always clear here since the previous
    // step shifted it out, so it doubles as a zero carry-in.
    add_n #(.N(WIDTH)) u_add (
        .x    (acc_q[PW-1:WIDTH]),
        .y    (addend),
        .cin  (acc_q[AW-1]),
        .sum  (sum),
        .cout (cout)
    );

    assign acc_sum   = {cout, sum, acc_q[WIDTH-1:0]};
    assign acc_shift = acc_sum >> 1;
    assign res_fin   = neg_q ? -acc_shift[PW-1:0] : acc_shift[PW-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE, FIN: begin
                if (state_q == FIN) state_d = IDLE;
                if (io.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    mcand_d = mag(io.a, io.is_signed);
                    acc_d   = {{(WIDTH + 1){1'b0}}, mag(io.b, io.is_signed)};
                    neg_d   = io.is_signed & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
                end
            end
            RUN: begin
                acc_d = acc_shift;
                cnt_d = cnt_q + cnt_t'(1);
                if (cnt_q == LAST) begin
                    state_d      = FIN;
                    {hi_d, lo_d} = res_fin;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign io.busy    = (state_q == RUN);
    assign io.done    = (state_q == FIN);
    assign io.prod_hi = hi_q;
    assign io.prod_lo = lo_q;

endmodule
